if_id_reg: RTL and testbench

IF/ID pipeline register for the five-stage MIPS core. It sits directly downstream of the fetch PC register and captures the fetched PC, instruction word and delay-slot flag every cycle. It also performs the fetch-stage address check, so a bad fetch address reaches decode as an AdEL exception code with a NOP in place of the instruction. It implements stall, eret clear and exception/interrupt flush, so decode always sees a coherent instruction or bubble.

---
 rtl/if_id_reg_pkg.sv | 14 +
 rtl/if_id_reg_if.sv | 26 ++
 rtl/if_id_reg_f_exc_chk.sv | 12 +
 rtl/if_id_reg.sv | 81 ++++++++
 tb/tb_if_id_reg.sv | 126 ++++++++++++
 5 files changed

// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID stage: exception codes, PC map and the NOP word.
package if_id_reg_pkg;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    localparam logic [31:0] PC_INIT  = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_6ffc;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch-to-decode bundle: fetch-side inputs, pipeline controls and registered decode outputs.
interface if_id_reg_if;

    logic        en;
    logic        req;
    logic        clr;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic        F_BD;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic [4:0]  D_excCode;
    logic        D_BD;
    logic        D_valid;

    modport master (
        output en, req, clr, F_PC, F_instr, F_BD,
        input  D_PC, D_instr, D_excCode, D_BD, D_valid
    );

    modport slave (
        input  en, req, clr, F_PC, F_instr, F_BD,
        output D_PC, D_instr, D_excCode, D_BD, D_valid
    );

endinterface

// File: rtl/if_id_reg_f_exc_chk.sv
// Fetch address check: flags misaligned or out-of-range instruction fetches (AdEL).
module f_exc_chk #(
    parameter logic [31:0] IM_LO = 32'h0000_3000,
    parameter logic [31:0] IM_HI = 32'h0000_6ffc
) (
    input  logic [31:0] pc_i,
    output logic        fault_o
);

    assign fault_o = (pc_i[1:0] != 2'b00) || (pc_i < IM_LO) || (pc_i > IM_HI);

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with fetch address check, stall, eret clear and exception flush.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] P_PC_INIT = PC_INIT,
    parameter logic [31:0] P_EXC_PC  = EXC_PC,
    parameter logic [31:0] P_IM_LO   = IM_LO,
    parameter logic [31:0] P_IM_HI   = IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    if_id_reg_if.slave  bus
);

    logic        fault;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  exc_q,   exc_d;
    logic        bd_q,    bd_d;
    logic        valid_q, valid_d;

    f_exc_chk #(
        .IM_LO (P_IM_LO),
        .IM_HI (P_IM_HI)
    ) u_f_exc_chk (
        .pc_i    (bus.F_PC),
        .fault_o (fault)
    );

    // reset is folded in here so the flops see a single next-state mux
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;
        if (!reset) begin
            pc_d    = P_PC_INIT;
            instr_d = NOP_WORD;
            exc_d   = EXC_NONE;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (bus.req) begin
            pc_d    = P_EXC_PC;
            instr_d = NOP_WORD;
            exc_d   = EXC_NONE;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (!bus.en) begin
            pc_d    = pc_q;
        end else if (bus.clr) begin
            pc_d    = bus.F_PC;
            instr_d = NOP_WORD;
            exc_d   = EXC_NONE;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else begin
            pc_d    = bus.F_PC;
            instr_d = fault ? NOP_WORD : bus.F_instr;
            exc_d   = fault ? EXC_ADEL : EXC_NONE;
            bd_d    = bus.F_BD;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
        exc_q   <= exc_d;
        bd_q    <= bd_d;
        valid_q <= valid_d;
    end

    assign bus.D_PC      = pc_q;
    assign bus.D_instr   = instr_q;
    assign bus.D_excCode = exc_q;
    assign bus.D_BD      = bd_q;
    assign bus.D_valid   = valid_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: behavioural model feeds a scoreboard queue checked one cycle later.
module tb_if_id_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t model;
    exp_t sb[$];

    if_id_reg_if bus ();

    if_id_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic bad_fetch(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6ffc);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic req, input logic clr,
                        input logic [31:0] pc, input logic [31:0] instr, input logic bd);
        exp_t e;
        reset       = rst;
        bus.en      = en;
        bus.req     = req;
        bus.clr     = clr;
        bus.F_PC    = pc;
        bus.F_instr = instr;
        bus.F_BD    = bd;
        if (!rst)        model = '{32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0};
        else if (req)    model = '{32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0};
        else if (!en)    model = model;
        else if (clr)    model = '{pc, 32'h0, 5'd0, 1'b0, 1'b0};
        else if (bad_fetch(pc)) model = '{pc, 32'h0, 5'd4, bd, 1'b1};
        else             model = '{pc, instr, 5'd0, bd, 1'b1};
        sb.push_back(model);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk32("D_PC",      bus.D_PC,             e.pc);
        chk32("D_instr",   bus.D_instr,          e.instr);
        chk32("D_excCode", {27'd0, bus.D_excCode}, {27'd0, e.exc});
        chk32("D_BD",      {31'd0, bus.D_BD},    {31'd0, e.bd});
        chk32("D_valid",   {31'd0, bus.D_valid}, {31'd0, e.valid});
    endtask

    initial begin
        model = '0;
        // reset for two cycles, then the first fetch
        step(0, 1, 0, 0, 32'h0000_1234, 32'hdead_beef, 1);
        step(0, 1, 0, 0, 32'h0000_1238, 32'hdead_beef, 1);
        chk32("rst_pc", bus.D_PC, 32'h0000_3000);
        step(1, 1, 0, 0, 32'h0000_3000, 32'h3c01_0001, 0);
        chk32("first_valid", {31'd0, bus.D_valid}, 32'd1);

        // stall holds the loaded word
        step(1, 1, 0, 0, 32'h0000_3004, 32'h3421_0002, 0);
        step(1, 0, 0, 0, 32'h0000_3008, 32'h1111_1111, 1);
        step(1, 0, 0, 0, 32'h0000_300c, 32'h2222_2222, 0);
        step(1, 0, 0, 0, 32'h0000_3010, 32'h3333_3333, 1);
        chk32("stall_pc", bus.D_PC, 32'h0000_3004);
        chk32("stall_instr", bus.D_instr, 32'h3421_0002);
        step(1, 1, 0, 0, 32'h0000_3008, 32'h0000_0020, 0);

        // fetch faults and range boundaries
        step(1, 1, 0, 0, 32'h0000_3002, 32'haaaa_aaaa, 0);
        chk32("misalign_exc", {27'd0, bus.D_excCode}, 32'd4);
        step(1, 1, 0, 0, 32'h0000_7000, 32'hbbbb_bbbb, 1);
        step(1, 1, 0, 0, 32'h0000_6ffc, 32'hcccc_cccc, 0);
        chk32("hi_ok_instr", bus.D_instr, 32'hcccc_cccc);
        step(1, 1, 0, 0, 32'h0000_2ffc, 32'hdddd_dddd, 0);
        step(1, 1, 0, 0, 32'h0000_3001, 32'heeee_eeee, 0);
        step(1, 1, 0, 0, 32'hffff_fffc, 32'h1234_5678, 1);

        // req overrides a stall
        step(1, 1, 0, 0, 32'h0000_300c, 32'h0800_0c00, 1);
        step(1, 0, 1, 0, 32'h0000_3010, 32'h5555_5555, 1);
        chk32("req_pc", bus.D_PC, 32'h0000_4180);

        // clr inserts a bubble at F_PC; clr under stall holds
        step(1, 1, 0, 1, 32'h0000_3010, 32'h6666_6666, 1);
        step(1, 1, 0, 0, 32'h0000_3014, 32'h7777_7777, 1);
        step(1, 0, 0, 1, 32'h0000_3018, 32'h8888_8888, 0);
        chk32("clr_stall_pc", bus.D_PC, 32'h0000_3014);

        // reset beats req and clr; reset mid-stall
        step(0, 1, 1, 1, 32'h0000_3020, 32'h9999_9999, 1);
        chk32("rst_prio_pc", bus.D_PC, 32'h0000_3000);
        step(1, 1, 0, 0, 32'h0000_3024, 32'h0123_4567, 1);
        step(1, 0, 0, 0, 32'h0000_3028, 32'h89ab_cdef, 0);
        step(0, 0, 0, 0, 32'h0000_302c, 32'h89ab_cdef, 0);

        // randomised mix
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                 32'h0000_2ff0 + 32'($urandom_range(0, 16'h4020)),
                 $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
